// File: rtl/fp_expand_accum_if.sv
// rtl/fp_expand_accum_if.sv - sample-in / result-out handshake bundle for fp_expand_accum
interface fp_expand_accum_if #(
  parameter int DW = 13,
  parameter int EW = 3,
  parameter int FW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          in_s;
  logic [EW-1:0] in_e;
  logic [FW-1:0] in_f;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_d;
  logic [DW-1:0] out_sum;
  logic          out_sat;

  modport master (
    output in_valid, in_s, in_e, in_f, out_ready,
    input  in_ready, out_valid, out_d, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_s, in_e, in_f, out_ready,
    output in_ready, out_valid, out_d, out_sum, out_sat
  );
endinterface

// File: rtl/fp_expand_accum.sv
// rtl/fp_expand_accum.sv - expands (S,E,F) samples by serial shifting and keeps a saturating running sum
module fp_expand_accum #(
  parameter int DW = 13,
  parameter int EW = 3,
  parameter int FW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acc_clr,
  fp_expand_accum_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, NEG, OUT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mag_q, mag_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          sgn_q, sgn_d;
  logic [DW-1:0] out_d_q, out_d_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          sat_q, sat_d;

  logic [DW-1:0] val;
  logic [DW-1:0] base;
  logic [DW:0]   sum_wide;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    out_d_d = out_d_q;
    sum_d   = sum_q;
    sat_d   = sat_q;

    val      = sgn_q ? -mag_q : mag_q;
    base     = acc_clr ? '0 : sum_q;
    sum_wide = {base[DW-1], base} + {val[DW-1], val};

    // Clear in NEG is folded into the add below (clear-then-add)
    if (acc_clr && state_q != NEG) begin
      sum_d = '0;
      sat_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mag_d   = {{(DW-FW){1'b0}}, bus.in_f};
          cnt_d   = bus.in_e;
          sgn_d   = bus.in_s;
          state_d = (bus.in_e != '0) ? SHIFT : NEG;
        end
      end
      SHIFT: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - EW'(1);
        if (cnt_q == EW'(1)) state_d = NEG;
      end
      NEG: begin
        out_d_d = val;
        sat_d   = acc_clr ? 1'b0 : sat_q;
        if (sum_wide[DW] != sum_wide[DW-1]) begin
          sum_d = sum_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
          sat_d = 1'b1;
        end else begin
          sum_d = sum_wide[DW-1:0];
        end
        state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      out_d_q <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      out_d_q <= out_d_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_d     = out_d_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: doc/fp_expand_accum.md
Name: fp_expand_accum

Overview:
- Downstream consumer of the floating-point converter's (S, E, F) output; value = (-1)^S * F * 2^E.
- Expands each sample back to a 13-bit two's-complement value using an iterative one-bit-per-cycle shifter.
- Keeps a saturating 13-bit running sum of all expanded samples.
- Valid/ready handshake on both input and output, so it can sit between the converter and a slower sink.

Parameters:
DW, 13, width of expanded value and running sum (two's complement)
EW, 3, exponent width
FW, 5, significand width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample present
in_ready  out  1  block can accept a sample (high only in IDLE)
in_s  in  1  sign bit
in_e  in  EW  exponent
in_f  in  FW  significand
acc_clr  in  1  synchronous clear of running sum and saturation flag
out_valid  out  1  expanded result available
out_ready  in  1  sink accepts result
out_d  out  DW  expanded sample, two's complement
out_sum  out  DW  running sum after this sample, two's complement
out_sat  out  1  sticky: running sum has clamped since last clear/reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0, out_d=0, out_sum=0, out_sat=0, in_ready=1.
  - Internal magnitude, count and sign registers are cleared.
  - Applies immediately, including mid-SHIFT or mid-OUT; the in-flight sample is dropped.
- FSM states: IDLE, SHIFT, NEG, OUT. in_ready = (state==IDLE); out_valid = (state==OUT).
- IDLE:
  - On in_valid, latch mag = zero-extended in_f (DW bits), cnt = in_e, sgn = in_s.
  - Next state is SHIFT if in_e!=0, else NEG.
- SHIFT: each cycle mag <= mag<<1, cnt <= cnt-1; go to NEG on the cycle cnt goes 1->0 (exactly E shifts).
- NEG:
  - out_d <= sgn ? -mag : mag; S=1 with F=0 yields out_d=0 (no negative zero).
  - Running-sum update uses a DW+1-bit add, then clamps to [-2^(DW-1), 2^(DW-1)-1] (-4096..4095).
  - On clamp, out_sat <= 1. Go to OUT.
- OUT:
  - out_d and out_sum are held stable while out_valid=1.
  - On out_ready, return to IDLE; in_ready rises the following cycle (one bubble per sample).
- Latency: with the accept edge counted as edge 0, out_valid rises after edge E+1 (E=0: 1 edge, E=7: 8 edges).
- Throughput: at most one sample per E+3 cycles.
- Non-normalised inputs (E>0, F<16) are legal and expand literally as F*2^E.
- Maximum |value| is 31*128=3968, so out_d never overflows. Only the sum saturates.
- acc_clr:
  - In any state other than NEG: sum <= 0 and out_sat <= 0 next edge; out_sum shows 0 once the clear is registered.
  - Coincident with NEG: clear-then-add, so sum <= out_d of the current sample and out_sat <= 0.
- in_valid outside IDLE is ignored; upstream must hold data until in_ready.
- Inputs are sampled only on the accept edge; changes afterwards do not affect the in-flight result.

Test Plan:
1. Reset, then S=0, E=7, F=11010, out_ready=1 -> out_valid after 8 edges; out_d=13'b0_1101_0000_0000 (3328), out_sum=3328, out_sat=0.
2. Following sample S=1, E=6, F=10101 -> out_d=13'b1_1010_1100_0000 (-1344), out_sum=1984. Then S=1, E=0, F=00001 -> out_valid 1 edge after accept, out_d=13'b1_1111_1111_1111, out_sum=1983.
3. Saturation, positive then negative:
   - acc_clr, then two samples S=0, E=7, F=11111 -> out_sum 3968, then 4095 with out_sat=1.
   - acc_clr, then two samples S=1, E=7, F=11111 -> out_sum -3968, then -4096, out_sat=1.
   - acc_clr pulse -> out_sum=0, out_sat=0.
4. Backpressure: hold out_ready=0 for 5 cycles in OUT while driving a new in_valid -> out_d/out_sum unchanged, in_ready=0, new sample not taken. Raise out_ready -> in_ready=1 on the next cycle, new sample accepted.
5. acc_clr asserted exactly in the NEG cycle of S=0, E=2, F=00011 with prior sum 1000 -> out_sum=12, not 1012; out_sat=0.
6. Reset mid-operation: rst_n low during SHIFT of an E=7 sample -> out_valid=0, out_d/out_sum/out_sat=0, in_ready=1 immediately. After release, next sample E=1, F=00010, S=0 -> out_d=4, out_sum=4.
